// File: rtl/range_result_buffer.sv
// range_result_buffer
// Small FIFO that collects results from an upstream range finder. A result
// is captured on each finish strobe that is not flagged as an error; the
// consumer drains it with a valid/ready handshake. Error strobes are counted
// (saturating) and results that arrive while the FIFO is full are dropped
// with a sticky overflow flag.
//
// Optional feature: define RANGE_MAX_TRACK_EN to track the largest captured
// result on max_range (dropped captures included). Without it max_range is 0.
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous, active-high reset
//   range_in      result from the range finder
//   finish_in     finish strobe (same as driven to the range finder)
//   error_in      debug_error from the range finder
//   out_data      head-of-FIFO result (don't-care while out_valid = 0)
//   out_valid     out_data holds a valid result
//   out_ready     consumer accepts out_data
//   count         number of occupied entries
//   overflow      sticky: a result was dropped
//   overflow_clr  clears overflow (a coincident drop wins)
//   err_count     saturating count of error_in cycles
//   max_range     largest captured result (0 when tracking not built)
module range_result_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         range_in,
  input  logic                     finish_in,
  input  logic                     error_in,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     overflow_clr,
  output logic [7:0]               err_count,
  output logic [WIDTH-1:0]         max_range
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [AW-1:0]    head, tail;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic [7:0]       err_q;

  logic capture, pop, full, wr_en, drop;

  assign capture = finish_in && !error_in;
  assign pop     = out_valid && out_ready;
  assign full    = (count_q == CW'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en   = capture && (!full || pop);
  assign drop    = capture && full && !pop;

  assign out_valid = (count_q != '0);
  assign out_data  = storage[head];
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign err_count = err_q;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) tail <= tail + AW'(1);
      if (pop)   head <= head + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; out_valid masks stale contents.
  always_ff @(posedge clock) begin
    if (wr_en) storage[tail] <= range_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)             overflow_q <= 1'b0;
    else if (drop)         overflow_q <= 1'b1;
    else if (overflow_clr) overflow_q <= 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          err_q <= '0;
    else if (error_in && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end

`ifdef RANGE_MAX_TRACK_EN
  logic [WIDTH-1:0] max_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                             max_q <= '0;
    else if (capture && range_in > max_q)  max_q <= range_in;
  end

  assign max_range = max_q;
`else
  assign max_range = '0;
`endif

endmodule

// File: tb/tb_range_result_buffer.sv
module tb_range_result_buffer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] range_in;
  logic             finish_in, error_in, out_ready, overflow_clr;
  logic [WIDTH-1:0] out_data, max_range;
  logic             out_valid, overflow;
  logic [2:0]       count;
  logic [7:0]       err_count;

  int pass_cnt = 0;
  int total    = 0;

  range_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .range_in(range_in), .finish_in(finish_in),
    .error_in(error_in), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .overflow(overflow),
    .overflow_clr(overflow_clr), .err_count(err_count), .max_range(max_range)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        f, e, r, c;
    logic [15:0] rng;
    int          cnt;
    logic        v;
    logic        cd;
    logic [15:0] d;
    logic        o;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic f, logic e, logic r, logic c, logic [15:0] rng,
                              int cnt, logic v, logic cd, logic [15:0] d, logic o);
    vec_t t;
    t.f = f; t.e = e; t.r = r; t.c = c; t.rng = rng;
    t.cnt = cnt; t.v = v; t.cd = cd; t.d = d; t.o = o;
    tbl.push_back(t);
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic drive(logic f, logic e, logic r, logic c, logic [15:0] rng);
    finish_in = f; error_in = e; out_ready = r; overflow_clr = c; range_in = rng;
  endtask

  // Apply inputs, take one edge, sample 1 time unit later.
  task automatic step(logic f, logic e, logic r, logic c, logic [15:0] rng);
    drive(f, e, r, c, rng);
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 16'h0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Reference model state
  int          mq[$];
  logic        m_ovf;
  int          m_err;
  int          m_max;

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 16'h0);
    #2 reset = 1'b1;
    #1;
    check("reset_count", count, 0);
    check("reset_valid", out_valid, 0);
    check("reset_overflow", overflow, 0);
    check("reset_err", err_count, 0);
    check("reset_max", max_range, 0);
    do_reset();

    // ---------------- table-driven sequences ----------------
    // Three pushes then drain in order
    add(1,0,0,0,16'h0010, 1,1,1,16'h0010,0);
    add(1,0,0,0,16'h0200, 2,1,1,16'h0010,0);
    add(1,0,0,0,16'h0003, 3,1,1,16'h0010,0);
    add(0,0,1,0,16'h0,    2,1,1,16'h0200,0);
    add(0,0,1,0,16'h0,    1,1,1,16'h0003,0);
    add(0,0,1,0,16'h0,    0,0,0,16'h0,0);
    add(0,0,1,0,16'h0,    0,0,0,16'h0,0);   // ready while empty is ignored
    // Error-flagged finish never writes
    add(1,1,0,0,16'h0777, 0,0,0,16'h0,0);
    // Five captures into a 4-deep FIFO, overflow, clear, drain
    for (int i = 1; i <= 4; i++) add(1,0,0,0,16'(i), i,1,1,16'h1,0);
    add(1,0,0,0,16'h5, 4,1,1,16'h1,1);
    add(0,0,0,1,16'h0, 4,1,1,16'h1,0);
    add(0,0,1,0,16'h0, 3,1,1,16'h2,0);
    add(0,0,1,0,16'h0, 2,1,1,16'h3,0);
    add(0,0,1,0,16'h0, 1,1,1,16'h4,0);
    add(0,0,1,0,16'h0, 0,0,0,16'h0,0);
    // Full FIFO with simultaneous capture and pop
    for (int i = 0; i < 4; i++) add(1,0,0,0,16'hA + 16'(i), i+1,1,1,16'hA,0);
    add(1,0,1,0,16'hE, 4,1,1,16'hB,0);
    add(0,0,1,0,16'h0, 3,1,1,16'hC,0);
    add(0,0,1,0,16'h0, 2,1,1,16'hD,0);
    add(0,0,1,0,16'h0, 1,1,1,16'hE,0);
    add(0,0,1,0,16'h0, 0,0,0,16'h0,0);
    // Clear coinciding with a new drop: set wins
    for (int i = 0; i < 4; i++) add(1,0,0,0,16'h21 + 16'(i), i+1,1,1,16'h21,0);
    add(1,0,0,0,16'h99, 4,1,1,16'h21,1);
    add(1,0,0,1,16'h98, 4,1,1,16'h21,1);
    add(0,0,0,1,16'h0,  4,1,1,16'h21,0);

    foreach (tbl[i]) begin
      step(tbl[i].f, tbl[i].e, tbl[i].r, tbl[i].c, tbl[i].rng);
      check($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
      check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].v);
      if (tbl[i].cd) check($sformatf("tbl%0d_data", i), out_data, tbl[i].d);
      check($sformatf("tbl%0d_overflow", i), overflow, tbl[i].o);
    end
    check("tbl_err_count", err_count, 1);

    // ---------------- 300 error cycles ----------------
    do_reset();
    repeat (300) step(1, 1, 0, 0, 16'h1234);
    check("err_count_sat", err_count, 255);
    check("err_no_write", count, 0);
    check("err_no_valid", out_valid, 0);

    // ---------------- max tracking ----------------
    do_reset();
    step(1, 0, 1, 0, 16'd5);
    step(1, 0, 1, 0, 16'd9);
    step(1, 0, 1, 0, 16'd2);
`ifdef RANGE_MAX_TRACK_EN
    check("max_range", max_range, 9);
`else
    check("max_range", max_range, 0);
`endif

    // ---------------- reset mid-operation ----------------
    do_reset();
    step(1, 0, 0, 0, 16'h0101);
    step(1, 0, 0, 0, 16'h0202);
    check("pre_reset_count", count, 2);
    drive(0, 0, 0, 0, 16'h0);
    #2 reset = 1'b1;
    #1;
    check("async_reset_valid", out_valid, 0);
    check("async_reset_count", count, 0);
    @(posedge clock); #1 reset = 1'b0;
    step(1, 0, 0, 0, 16'h0042);
    check("post_reset_data", out_data, 16'h0042);
    check("post_reset_count", count, 1);
    check("post_reset_valid", out_valid, 1);

    // ---------------- randomized vs reference model ----------------
    do_reset();
    mq.delete(); m_ovf = 0; m_err = 0; m_max = 0;
    for (int n = 0; n < 500; n++) begin
      logic f, e, r, c;
      logic [15:0] rng;
      bit cap, pp, full;
      f   = ($urandom_range(0, 99) < 55);
      e   = ($urandom_range(0, 99) < 10);
      r   = ($urandom_range(0, 99) < 40);
      c   = ($urandom_range(0, 99) < 8);
      rng = 16'($urandom);
      cap  = f && !e;
      full = (mq.size() == DEPTH);
      pp   = (mq.size() != 0) && r;
      if (pp) void'(mq.pop_front());
      if (cap) begin
        if (!full || pp) mq.push_back(int'(rng));
        else m_ovf = 1;
        if (int'(rng) > m_max) m_max = int'(rng);
      end
      if (c && !(cap && full && !pp)) m_ovf = 0;
      if (e && m_err < 255) m_err++;
      step(f, e, r, c, rng);
      check($sformatf("rnd%0d_count", n), count, mq.size());
      check($sformatf("rnd%0d_valid", n), out_valid, mq.size() != 0);
      if (mq.size() != 0) check($sformatf("rnd%0d_data", n), out_data, mq[0]);
      check($sformatf("rnd%0d_overflow", n), overflow, m_ovf);
      check($sformatf("rnd%0d_err", n), err_count, m_err);
`ifdef RANGE_MAX_TRACK_EN
      check($sformatf("rnd%0d_max", n), max_range, m_max);
`else
      check($sformatf("rnd%0d_max", n), max_range, 0);
`endif
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/range_result_buffer.md
RANGE_RESULT_BUFFER -- requirements
Module: range_result_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, result width; equals the width of the upstream range finder.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, >= 2.
REQ-003 SHALL have port clock  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port range_in  input  WIDTH  range result from the upstream range finder.
REQ-006 SHALL have port finish_in  input  1  the same finish strobe driven to the range finder.
REQ-007 SHALL have port error_in  input  1  debug_error from the range finder.
REQ-008 SHALL have port out_data  output  WIDTH  head-of-FIFO result.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid result.
REQ-010 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-012 SHALL have port overflow  output  1  sticky flag: a result was dropped.
REQ-013 SHALL have port overflow_clr  input  1  clears overflow.
REQ-014 SHALL have port err_count  output  8  number of error_in cycles.
REQ-015 SHALL have port max_range  output  WIDTH  largest captured result (see Configuration).

Function
REQ-016 SHALL define capture = finish_in && !error_in, sampled on the rising clock edge.
REQ-017 SHALL define pop = out_valid && out_ready.
REQ-018 On capture with count < DEPTH, SHALL write range_in at the tail pointer and increment count.
REQ-019 On pop, SHALL advance the head pointer and decrement count.
REQ-020 On capture and pop in the same cycle, SHALL write and read, with count unchanged; this includes the full case, where the capture is accepted.
REQ-021 On capture with count == DEPTH and no pop, SHALL drop the result, leave the FIFO unchanged, and set overflow on the next edge.
REQ-022 SHALL wrap pointers modulo DEPTH; full and empty are distinguished by count alone.
REQ-023 SHALL have out_valid = (count != 0), driven from registered state only.
REQ-024 Capture-to-out_valid latency SHALL be 1 cycle when empty.
REQ-025 out_data SHALL equal storage[head] and SHALL stay stable while out_valid && !out_ready.
REQ-026 out_data SHALL be don't-care while out_valid = 0.
REQ-027 overflow SHALL clear on overflow_clr; if overflow_clr coincides with a new drop, set SHALL win.
REQ-028 err_count SHALL increment once per cycle with error_in = 1 and saturate at 255.
REQ-029 error_in SHALL never cause a FIFO write, even with finish_in = 1.
REQ-030 Pop when empty SHALL be impossible (out_valid = 0); out_ready SHALL be ignored while empty.

Reset
REQ-031 reset SHALL force count = 0, head = tail = 0, out_valid = 0, overflow = 0, err_count = 0, max_range = 0, asynchronously.
REQ-032 Storage contents SHALL NOT need to be reset.
REQ-033 Reset mid-operation SHALL discard all buffered results; the first capture after release SHALL appear at out_data with count = 1.

Configuration
REQ-034 Macro RANGE_MAX_TRACK_EN SHALL select max tracking.
REQ-035 With RANGE_MAX_TRACK_EN defined, max_range SHALL load range_in on every capture where range_in > max_range, including dropped captures.
REQ-036 Without RANGE_MAX_TRACK_EN, max_range SHALL be tied to 0 and the tracking register SHALL not be built.

Verification
REQ-037 Push 0x0010, 0x0200, 0x0003 with out_ready = 0, then set out_ready = 1 -> out_data 0x0010, 0x0200, 0x0003 on consecutive cycles; count 3,2,1,0.
REQ-038 DEPTH = 4: five captures with out_ready = 0 -> count = 4, overflow = 1, fifth value absent; pulse overflow_clr -> overflow = 0.
REQ-039 Full FIFO, capture and pop in the same cycle -> count stays 4, overflow stays 0, new value is last out.
REQ-040 finish_in = 1 with error_in = 1 for 300 cycles -> no FIFO write, err_count = 255.
REQ-041 With RANGE_MAX_TRACK_EN defined, captures 5, 9, 2 -> max_range = 9; without the macro -> max_range = 0.
REQ-042 Assert reset with count = 2 -> out_valid = 0 and count = 0 immediately; capture 0x0042 after release -> out_data = 0x0042 one cycle later.
